// File: rtl/seq_det_pkg.sv
// Shared definitions for the time-shared 1011 sequence detector:
// state encodings, state width and the single next-state function.
package seq_det_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'b000,  // idle / no progress
    S1 = 3'b001,  // seen "1"
    S2 = 3'b010,  // seen "10"
    S3 = 3'b011,  // seen "101"
    S4 = 3'b100   // seen "1011" (pattern complete, overlapping)
  } state_t;

  // Overlapping 1011 detector transition function.
  function automatic state_t next_state(input state_t cur, input logic bit_in);
    state_t nxt;
    case (cur)
      S0:      nxt = bit_in ? S1 : S0;
      S1:      nxt = bit_in ? S1 : S2;
      S2:      nxt = bit_in ? S3 : S0;
      S3:      nxt = bit_in ? S4 : S2;
      S4:      nxt = bit_in ? S1 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first requester searching upward from ptr+1,
// wrapping around to 0. Purely combinational.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic found;

  // Pick the lowest requester above ptr; failing that, the lowest overall.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(ptr))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// NCH serial requesters share one 1011 detector next-state function.
// A round-robin arbiter grants one channel per cycle; that channel's saved
// state is advanced and completed patterns are reported one cycle later.
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         ch_clear,
  output logic                   hit_valid,
  output logic [$clog2(NCH)-1:0] hit_ch,
  output logic [CW-1:0]          hit_total
);

  localparam int              IW        = $clog2(NCH);
  localparam logic [IW-1:0]   PTR_RST   = IW'(NCH - 1);
  localparam logic [CW-1:0]   TOTAL_MAX = '1;

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            hit_valid_q, hit_valid_d;
  logic [IW-1:0]   hit_ch_q, hit_ch_d;
  logic [CW-1:0]   hit_total_q, hit_total_d;

  logic [NCH-1:0]  grant;
  logic            xfer;
  logic [IW-1:0]   gnt_idx;
  state_t          cur_state, nxt_state;
  logic            cur_bit;
  logic            gnt_clear;

  rr_arbiter #(.N(NCH)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign req_ready = reset ? grant : '0;

  // Mux the granted channel onto the single shared next-state function.
  always_comb begin
    xfer      = |(req_valid & req_ready);
    gnt_idx   = '0;
    cur_state = S0;
    cur_bit   = 1'b0;
    gnt_clear = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (req_ready[i]) begin
        gnt_idx   = IW'(i);
        cur_state = state_q[i];
        cur_bit   = req_bit[i];
        gnt_clear = ch_clear[i];
      end
    end
    nxt_state = next_state(cur_state, cur_bit);
  end

  // Next-state for pointer, saved states, hit pulse and saturating total.
  always_comb begin
    ptr_d       = ptr_q;
    hit_valid_d = 1'b0;
    hit_ch_d    = '0;
    hit_total_d = hit_total_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
    end
    if (xfer) begin
      ptr_d = gnt_idx;
      for (int i = 0; i < NCH; i++) begin
        if (req_ready[i]) state_d[i] = nxt_state;
      end
      // A clear on the granted channel discards the bit, so no hit either.
      if (nxt_state == S4 && !gnt_clear) begin
        hit_valid_d = 1'b1;
        hit_ch_d    = gnt_idx;
        if (hit_total_q != TOTAL_MAX) hit_total_d = hit_total_q + 1'b1;
      end
    end
    // Clear wins over any update made by a coincident transfer.
    for (int i = 0; i < NCH; i++) begin
      if (ch_clear[i]) state_d[i] = S0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      // NOTE: saved states are ordinary flops, not a RAM, so they take the
      // reset with everything else and partial progress is discarded.
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= S0;
      end
      ptr_q       <= PTR_RST;
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
      hit_total_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
      end
      ptr_q       <= ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_ch_q    <= hit_ch_d;
      hit_total_q <= hit_total_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_ch    = hit_ch_q;
  assign hit_total = hit_total_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter: a default instance (NCH=4, CW=16)
// and a CW=2 instance sharing the same stimulus for saturation.
module tb_seq_detect_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_bit;
  logic [3:0]  ch_clear;

  logic [3:0]  req_ready;
  logic        hit_valid;
  logic [1:0]  hit_ch;
  logic [15:0] hit_total;

  logic [3:0]  sat_ready;
  logic        sat_hit_valid;
  logic [1:0]  sat_hit_ch;
  logic [1:0]  sat_hit_total;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_arbiter #(.NCH(4), .CW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .ch_clear  (ch_clear),
    .hit_valid (hit_valid),
    .hit_ch    (hit_ch),
    .hit_total (hit_total)
  );

  seq_detect_arbiter #(.NCH(4), .CW(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (sat_ready),
    .ch_clear  (ch_clear),
    .hit_valid (sat_hit_valid),
    .hit_ch    (sat_hit_ch),
    .hit_total (sat_hit_total)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, let combinational outputs settle.
  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    req_valid = v;
    req_bit   = b;
    ch_clear  = c;
    #1;
  endtask

  // Cross one rising edge and sample registered outputs just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    logic [6:0] seq7;
    logic [6:0] hits7;
    logic [2:0] bits3;
    pat   = 4'b1011;
    seq7  = 7'b1011011;
    hits7 = 7'b0001001;
    bits3 = 3'b101;

    reset     = 1'b0;
    req_valid = '0;
    req_bit   = '0;
    ch_clear  = '0;

    // Reset: nothing granted while reset is low, outputs cleared.
    drive(4'hf, 4'h0, 4'h0);
    check("rst_ready", req_ready, 4'b0000);
    tick();
    check("rst_hit_valid", hit_valid, 1'b0);
    check("rst_hit_ch", hit_ch, 2'd0);
    check("rst_total", hit_total, 16'd0);
    check("rst_sat_total", sat_hit_total, 2'd0);
    reset = 1'b1;

    // Single channel 0 sends 1,0,1,1: one hit, one cycle after 4th transfer.
    for (int k = 0; k < 4; k++) begin
      drive(4'b0001, {3'b000, pat[3-k]}, 4'h0);
      check("t1_ready", req_ready, 4'b0001);
      tick();
      check("t1_hit_valid", hit_valid, (k == 3));
    end
    check("t1_hit_ch", hit_ch, 2'd0);
    check("t1_total", hit_total, 16'd1);
    drive(4'h0, 4'h0, 4'h0);
    tick();
    check("t1_idle_hit_valid", hit_valid, 1'b0);
    check("t1_idle_hit_ch", hit_ch, 2'd0);

    // Channel 0 restarted from S0, bits 1011011: overlapping hits at 4 and 7.
    drive(4'h0, 4'h0, 4'b0001);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(4'b0001, {3'b000, seq7[6-k]}, 4'h0);
      tick();
      check("t2_hit_valid", hit_valid, hits7[6-k]);
    end
    check("t2_total", hit_total, 16'd3);

    // Reset again (pointer back to 3), then all four channels valid.
    reset = 1'b0;
    drive(4'h0, 4'h0, 4'h0);
    tick();
    reset = 1'b1;
    check("t3_total_after_rst", hit_total, 16'd0);
    for (int t = 0; t < 16; t++) begin
      drive(4'hf, {4{pat[3-(t/4)]}}, 4'h0);
      check("t3_grant", req_ready, 4'b0001 << (t % 4));
      tick();
      check("t3_hit_valid", hit_valid, (t >= 12));
      check("t3_hit_ch", hit_ch, (t >= 12) ? (t % 4) : 0);
    end
    check("t3_total", hit_total, 16'd4);
    drive(4'h0, 4'h0, 4'h0);
    tick();
    check("t3_idle_hit_valid", hit_valid, 1'b0);

    // Channel 2: 1,0,1 then a 1 coincident with ch_clear[2] -> no hit.
    drive(4'h0, 4'h0, 4'b0100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0100, {1'b0, bits3[2-k], 2'b00}, 4'h0);
      check("t4_ready", req_ready, 4'b0100);
      tick();
      check("t4_hit_valid", hit_valid, 1'b0);
    end
    drive(4'b0100, 4'b0100, 4'b0100);
    check("t4_ready_with_clear", req_ready, 4'b0100);
    tick();
    check("t4_clear_no_hit", hit_valid, 1'b0);
    check("t4_clear_total", hit_total, 16'd4);
    // A further 1 lands in S1; then 0,1,1 completes only if that held.
    drive(4'b0100, 4'b0100, 4'h0);
    tick();
    check("t4_s1_no_hit", hit_valid, 1'b0);
    drive(4'b0100, 4'b0000, 4'h0);
    tick();
    check("t4_s2_no_hit", hit_valid, 1'b0);
    drive(4'b0100, 4'b0100, 4'h0);
    tick();
    check("t4_s3_no_hit", hit_valid, 1'b0);
    // Clearing channel 0 must not disturb the transfer on channel 2.
    drive(4'b0100, 4'b0100, 4'b0001);
    tick();
    check("t4_other_clear_hit", hit_valid, 1'b1);
    check("t4_other_clear_ch", hit_ch, 2'd2);
    check("t4_total", hit_total, 16'd5);

    // Channel 1: 1,0,1, reset for one cycle, then 1 -> no hit.
    drive(4'h0, 4'h0, 4'b0010);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0010, {2'b00, bits3[2-k], 1'b0}, 4'h0);
      tick();
      check("t5_hit_valid", hit_valid, 1'b0);
    end
    reset = 1'b0;
    drive(4'b0010, 4'b0010, 4'h0);
    check("t5_ready_in_rst", req_ready, 4'b0000);
    tick();
    reset = 1'b1;
    check("t5_rst_hit", hit_valid, 1'b0);
    check("t5_rst_total", hit_total, 16'd0);
    drive(4'b0010, 4'b0010, 4'h0);
    check("t5_ready", req_ready, 4'b0010);
    tick();
    check("t5_no_hit", hit_valid, 1'b0);
    check("t5_total", hit_total, 16'd0);
    check("t5_sat_total", sat_hit_total, 2'd0);

    // Seven 1011 patterns on channel 0: CW=2 total saturates at 3.
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 4; k++) begin
        drive(4'b0001, {3'b000, pat[3-k]}, 4'h0);
        tick();
        check("t6_hit_valid", hit_valid, (k == 3));
        check("t6_sat_hit_valid", sat_hit_valid, (k == 3));
      end
      check("t6_total", hit_total, p + 1);
      check("t6_sat_total", sat_hit_total, (p + 1 > 3) ? 3 : p + 1);
    end
    drive(4'h0, 4'h0, 4'h0);
    tick();
    check("t6_idle_sat_hit", sat_hit_valid, 1'b0);
    check("t6_idle_sat_ch", sat_hit_ch, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
